// File: rtl/spi_param_scheduler_if.sv
// spi_param_scheduler_if: parameter-write handshake (addr, data, we from master; ready from slave)
interface spi_param_scheduler_if;
  logic [3:0] param_addr;
  logic [11:0] param_data;
  logic param_we;
  logic param_ready;
  modport master(output param_addr, param_data, param_we, input param_ready);
  modport slave(input param_addr, param_data, param_we, output param_ready);
endinterface

// File: rtl/spi_param_scheduler.sv
// spi_param_scheduler: syncs SPI word strobe, decodes [15:12] addr / [11:0] value, issues one parameter write at a time, keeps shadow regs (ports: clock, reset async high, word_in, word_strobe, param handshake if, param_bus, dropped_count, err_count, link_timeout; optional watchdog under PARAM_WATCHDOG_EN)
module spi_param_scheduler #(
  parameter int NUM_REGS = 8,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic [15:0] word_in,
  input  logic word_strobe,
  spi_param_scheduler_if.master param,
  output logic [NUM_REGS*12-1:0] param_bus,
  output logic [7:0] dropped_count,
  output logic [7:0] err_count,
  output logic link_timeout
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_next;
  logic s1, s2, s3, strobe_edge, valid, accept, hs, wd_fire;
  assign strobe_edge = s2 & ~s3;
  assign valid = {1'b0, word_in[15:12]} < 5'(NUM_REGS);
  assign accept = state == IDLE && strobe_edge && valid;
  assign hs = param.param_we & param.param_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {s1, s2, s3} <= 3'b000;
      state <= IDLE;
    end else begin
      {s1, s2, s3} <= {word_strobe, s1, s2};
      state <= state_next;
    end
  end
  always_comb begin
    state_next = state == IDLE ? (accept ? ISSUE : IDLE) : (param.param_ready ? IDLE : ISSUE);
    param.param_we = state == ISSUE;
  end
  // the addr/data outputs are the hold register; never reloaded while a write is pending
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      param.param_addr <= 4'd0;
      param.param_data <= 12'd0;
    end else if (accept) begin
      param.param_addr <= word_in[15:12];
      param.param_data <= word_in[11:0];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped_count <= 8'd0;
      err_count <= 8'd0;
    end else begin
      if (strobe_edge && state == ISSUE && dropped_count != 8'hff) dropped_count <= dropped_count + 8'd1;
      if (strobe_edge && state == IDLE && !valid && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) param_bus <= '0;
    else if (wd_fire) param_bus <= '0;
    else if (hs)
      for (int i = 0; i < NUM_REGS; i++)
        if (param.param_addr == 4'(i)) param_bus[i*12+:12] <= param.param_data;
  end
`ifdef PARAM_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  // a handshake in the expiry cycle wins: the write lands and the link stays up
  assign wd_fire = !link_timeout && !hs && wd_cnt == WW'(WDOG_CYCLES - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      link_timeout <= 1'b0;
    end else if (hs) begin
      wd_cnt <= '0;
      link_timeout <= 1'b0;
    end else if (!link_timeout) begin
      wd_cnt <= wd_cnt + 1'b1;
      link_timeout <= wd_fire;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign link_timeout = 1'b0;
  if (WDOG_CYCLES < 1) begin : g_wdog_invalid
  end
`endif
endmodule

// File: tb/tb_spi_param_scheduler.sv
// tb_spi_param_scheduler: directed + randomized stimulus against a transaction-level reference model
module tb_spi_param_scheduler;
  localparam int WD = 100;
  logic clock = 1'b0, reset = 1'b1, word_strobe = 1'b0, rdy = 1'b1, rnd_rdy = 1'b0, chk_en = 1'b0;
  logic [15:0] word_in = 16'd0;
  logic [95:0] param_bus;
  logic [7:0] dropped_count, err_count;
  logic link_timeout;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int t; logic [15:0] w;} arr_t;
  arr_t q[$];
  logic m_pend, m_to, hs, arr, nw;
  logic [3:0] m_addr;
  logic [11:0] m_data;
  logic [11:0] m_sh [8];
  logic [7:0] m_drop, m_err;
  logic [15:0] w;
  logic [95:0] eb;
  int m_wd;
  spi_param_scheduler_if pif();
  assign pif.param_ready = rdy;
  spi_param_scheduler #(.NUM_REGS(8), .WDOG_CYCLES(WD)) dut (
    .clock(clock), .reset(reset), .word_in(word_in), .word_strobe(word_strobe),
    .param(pif), .param_bus(param_bus), .dropped_count(dropped_count),
    .err_count(err_count), .link_timeout(link_timeout));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // a word takes effect on the third rising edge after the strobe is raised; a write completes on any edge with ready high
  always begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      {m_pend, m_to, m_addr, m_data, m_drop, m_err} = '0;
      m_wd = 0;
      for (int i = 0; i < 8; i++) m_sh[i] = 12'd0;
      q.delete();
    end else begin
      hs = m_pend && rdy;
      arr = q.size() > 0 && q[0].t == cyc;
      nw = 1'b0;
      w = 16'd0;
      if (arr) begin
        w = q.pop_front().w;
        if (m_pend) m_drop = m_drop == 8'hff ? m_drop : m_drop + 8'd1;
        else if (w[15:12] < 4'd8) nw = 1'b1;
        else m_err = m_err == 8'hff ? m_err : m_err + 8'd1;
      end
      if (hs) begin
        m_sh[m_addr[2:0]] = m_data;
        m_pend = 1'b0;
        m_wd = 0;
        m_to = 1'b0;
      end
`ifdef PARAM_WATCHDOG_EN
      else if (!m_to) begin
        m_wd++;
        if (m_wd == WD) begin
          m_to = 1'b1;
          for (int i = 0; i < 8; i++) m_sh[i] = 12'd0;
        end
      end
`endif
      if (nw) {m_pend, m_addr, m_data} = {1'b1, w};
    end
    #1;
    if (chk_en && !reset) begin
      for (int i = 0; i < 8; i++) eb[i*12+:12] = m_sh[i];
      check("we", pif.param_we, m_pend);
      check("addr", pif.param_addr, m_addr);
      check("data", pif.param_data, m_data);
      check("bus", param_bus, eb);
      check("dropped", dropped_count, m_drop);
      check("err", err_count, m_err);
      check("timeout", link_timeout, m_to);
    end
  end
  task automatic tick();
    @(negedge clock);
    if (rnd_rdy) rdy = $urandom_range(0, 3) != 0;
  endtask
  task automatic send(input logic [15:0] wd, input int hold, input int gap);
    tick();
    word_in = wd;
    word_strobe = 1'b1;
    q.push_back('{cyc + 3, wd});
    repeat (hold) tick();
    word_strobe = 1'b0;
    repeat (gap) tick();
  endtask
  initial begin
    #1;
    check("rst_we", pif.param_we, 1'b0);
    check("rst_addr", pif.param_addr, 4'd0);
    check("rst_data", pif.param_data, 12'd0);
    check("rst_bus", param_bus, 96'd0);
    check("rst_drop", dropped_count, 8'd0);
    check("rst_err", err_count, 8'd0);
    check("rst_to", link_timeout, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();
    send(16'h2ABC, 3, 2);
    repeat (3) tick();
    check("reg2", param_bus[35:24], 12'hABC);
    rdy = 1'b0;
    send(16'h1123, 3, 1);
    repeat (6) tick();
    check("hold_we", pif.param_we, 1'b1);
    check("hold_addr", pif.param_addr, 4'd1);
    check("hold_data", pif.param_data, 12'h123);
    send(16'h3456, 3, 1);
    check("drop1", dropped_count, 8'd1);
    rdy = 1'b1;
    repeat (3) tick();
    check("reg1", param_bus[23:12], 12'h123);
    check("reg3", param_bus[47:36], 12'h000);
    send(16'h9FFF, 3, 1);
    repeat (2) tick();
    check("err1", err_count, 8'd1);
    repeat (299) send(16'h9FFF, 3, 1);
    check("err_sat", err_count, 8'd255);
    rdy = 1'b0;
    send(16'h5ABC, 3, 1);
    check("pre_rst_we", pif.param_we, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_we", pif.param_we, 1'b0);
    check("arst_drop", dropped_count, 8'd0);
    check("arst_err", err_count, 8'd0);
    check("arst_bus", param_bus, 96'd0);
    repeat (2) tick();
    reset = 1'b0;
    rdy = 1'b1;
    repeat (2) tick();
    send(16'h0555, 3, 2);
    repeat (110) tick();
`ifdef PARAM_WATCHDOG_EN
    check("wd_to", link_timeout, 1'b1);
    check("wd_reg0", param_bus[11:0], 12'h000);
`else
    check("wd_to", link_timeout, 1'b0);
    check("wd_reg0", param_bus[11:0], 12'h555);
`endif
    send(16'h0777, 3, 2);
    tick();
    check("wd_clr", link_timeout, 1'b0);
    check("wd_reg0b", param_bus[11:0], 12'h777);
    rnd_rdy = 1'b1;
    repeat (200) send(16'($urandom), $urandom_range(3, 5), $urandom_range(1, 3));
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
